// File: rtl/exec_sequencer.sv
// exec_sequencer: execute-stage issue/retire controller timing ALU/MUL/DIV latency and holding the result tag for writeback.
// Optional perf counters enabled by defining EXEC_SEQ_PERF_EN.
module exec_sequencer #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [1:0]  IN_CLASS,
  input  logic [4:0]  IN_RD,
  output logic        EX_START,
  output logic [1:0]  EX_CLASS,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [4:0]  OUT_RD,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic [31:0] PERF_STALL,
  output logic [31:0] PERF_OPS
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d, lat;
  logic [1:0]  cls_q, cls_d;
  logic [4:0]  rd_q, rd_d;
  logic        accept;
  always_comb begin
    lat      = IN_CLASS == 2'd1 ? 6'(MUL_LAT) : IN_CLASS == 2'd2 ? 6'(DIV_LAT) : 6'd1;
    IN_READY = !FLUSH && (state_q == IDLE || (state_q == DONE && OUT_READY));
    accept   = IN_VALID && IN_READY;
    state_d  = state_q;
    cnt_d    = cnt_q;
    cls_d    = cls_q;
    rd_d     = rd_q;
    if (FLUSH) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      cls_d   = IN_CLASS;
      rd_d    = IN_RD;
      state_d = lat == 6'd1 ? DONE : EXEC;
      cnt_d   = lat == 6'd1 ? 6'd0 : lat - 6'd2;
    end else if (state_q == EXEC) begin
      state_d = cnt_q == 6'd0 ? DONE : EXEC;
      cnt_d   = cnt_q == 6'd0 ? 6'd0 : cnt_q - 6'd1;
    end else if (state_q == DONE && OUT_READY) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cls_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cls_q   <= cls_d;
      rd_q    <= rd_d;
    end
  end
  assign EX_START  = accept;
  assign EX_CLASS  = cls_q;
  assign OUT_RD    = rd_q;
  assign OUT_VALID = state_q == DONE;
  assign BUSY      = state_q != IDLE;
`ifdef EXEC_SEQ_PERF_EN
  logic [31:0] stall_q, stall_d, ops_q, ops_d;
  // A DONE result killed by FLUSH is not a retirement.
  always_comb begin
    stall_d = stall_q + 32'(IN_VALID && !IN_READY);
    ops_d   = ops_q + 32'(OUT_VALID && OUT_READY && !FLUSH);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      ops_q   <= '0;
    end else begin
      stall_q <= stall_d;
      ops_q   <= ops_d;
    end
  end
  assign PERF_STALL = stall_q;
  assign PERF_OPS   = ops_q;
`else
  assign PERF_STALL = '0;
  assign PERF_OPS   = '0;
`endif
endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed stimulus with a retirement scoreboard checking tag order and handshake cycle.
module tb_exec_sequencer;
  logic        CLK = 0, RST = 1, IN_VALID = 0, OUT_READY = 1, FLUSH = 0;
  logic [1:0]  IN_CLASS = 0;
  logic [4:0]  IN_RD = 0;
  logic        IN_READY, EX_START, OUT_VALID, BUSY;
  logic [1:0]  EX_CLASS;
  logic [4:0]  OUT_RD;
  logic [31:0] PERF_STALL, PERF_OPS;
  typedef struct {logic [4:0] rd; int cyc;} exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0;
  exec_sequencer #(.MUL_LAT(3), .DIV_LAT(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_CLASS(IN_CLASS),
    .IN_RD(IN_RD), .EX_START(EX_START), .EX_CLASS(EX_CLASS), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_RD(OUT_RD), .FLUSH(FLUSH), .BUSY(BUSY),
    .PERF_STALL(PERF_STALL), .PERF_OPS(PERF_OPS)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic v, input logic [1:0] c, input logic [4:0] r);
    IN_VALID = v;
    IN_CLASS = c;
    IN_RD    = r;
    #1;
  endtask
  task automatic push(input logic [4:0] r, input int at);
    q.push_back('{r, at});
  endtask
  always @(negedge CLK) begin
    if (!RST && OUT_VALID && OUT_READY && !FLUSH) begin
      if (q.size() == 0) chk("unexpected_retire", {27'd0, OUT_RD}, 32'hffff_ffff);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("retire_rd", {27'd0, OUT_RD}, {27'd0, e.rd});
        chk("retire_cycle", cyc, e.cyc);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int c, s0, o0;
    tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_rd", OUT_RD, 0);
    chk("rst_ex_class", EX_CLASS, 0);
    chk("rst_perf_stall", PERF_STALL, 0);
    chk("rst_perf_ops", PERF_OPS, 0);
    RST = 0;
    tick();
    chk("rst_in_ready", IN_READY, 1);
    // ALU op, tag 5
    drive(1, 0, 5);
    chk("alu_ex_start", EX_START, 1);
    push(5, cyc + 1);
    tick();
    drive(0, 0, 0);
    chk("alu_out_valid", OUT_VALID, 1);
    chk("alu_out_rd", OUT_RD, 5);
    tick();
    chk("alu_idle", BUSY, 0);
    chk("alu_valid_drop", OUT_VALID, 0);
    // three back-to-back MULs
    c = cyc;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'(10 + i));
      chk("mul_ex_start", EX_START, 1);
      push(5'(10 + i), c + 3 * i + 3);
      tick();
      chk("mul_ex_class", EX_CLASS, 1);
      chk("mul_wait1", EX_START, 0);
      chk("mul_busy1", BUSY, 1);
      tick();
      chk("mul_wait2", EX_START, 0);
      chk("mul_busy2", BUSY, 1);
      tick();
    end
    drive(0, 0, 0);
    chk("mul_last_valid", OUT_VALID, 1);
    tick();
    chk("mul_idle", BUSY, 0);
    // DIV with 5 cycles of writeback backpressure and decode stalled behind it
    s0 = PERF_STALL;
    c = cyc;
    drive(1, 2, 7);
    chk("div_ex_start", EX_START, 1);
    tick();
    OUT_READY = 0;
    drive(1, 0, 8);
    for (int k = 1; k <= 36; k++) begin
      chk("div_in_ready", IN_READY, 0);
      if (k >= 32) begin
        chk("div_hold_valid", OUT_VALID, 1);
        chk("div_hold_rd", OUT_RD, 7);
      end else chk("div_not_done", OUT_VALID, 0);
      tick();
    end
    OUT_READY = 1;
    #1;
    push(7, c + 37);
    chk("div_next_start", EX_START, 1);
    push(8, c + 38);
`ifdef EXEC_SEQ_PERF_EN
    chk("div_perf_stall", PERF_STALL - s0, 36);
`else
    chk("div_perf_stall", PERF_STALL, 0);
`endif
    tick();
    drive(0, 0, 0);
    tick();
    // FLUSH aborts an in-flight DIV
    c = cyc;
    drive(1, 2, 20);
    chk("fl_div_start", EX_START, 1);
    tick();
    drive(0, 0, 0);
    repeat (9) tick();
    FLUSH = 1;
    drive(1, 0, 21);
    chk("fl_in_ready", IN_READY, 0);
    chk("fl_no_start", EX_START, 0);
    chk("fl_busy_before", BUSY, 1);
    tick();
    FLUSH = 0;
    #1;
    chk("fl_busy_after", BUSY, 0);
    chk("fl_valid_after", OUT_VALID, 0);
    chk("fl_next_start", EX_START, 1);
    push(21, cyc + 1);
    tick();
    drive(0, 0, 0);
    tick();
    // FLUSH in DONE with OUT_READY high is not a transfer
    drive(1, 0, 22);
    tick();
    drive(0, 0, 0);
    o0 = PERF_OPS;
    FLUSH = 1;
    tick();
    FLUSH = 0;
    #1;
    chk("fl_done_ops", PERF_OPS, o0);
    chk("fl_done_valid", OUT_VALID, 0);
    // async reset mid-MUL
    drive(1, 1, 30);
    tick();
    drive(0, 0, 0);
    chk("rst_mid_busy_pre", BUSY, 1);
    RST = 1;
    #1;
    chk("rst_mid_busy", BUSY, 0);
    chk("rst_mid_rd", OUT_RD, 0);
    chk("rst_mid_class", EX_CLASS, 0);
    chk("rst_mid_valid", OUT_VALID, 0);
    chk("rst_mid_perf_ops", PERF_OPS, 0);
    tick();
    RST = 0;
    #1;
    // four ALU-latency ops back to back, class 3 treated as ALU
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      drive(1, (i % 2) ? 2'd3 : 2'd0, 5'(31 - i));
      chk("alu4_ex_start", EX_START, 1);
      push(5'(31 - i), c + i + 1);
      tick();
    end
    drive(0, 0, 0);
    tick();
`ifdef EXEC_SEQ_PERF_EN
    chk("perf_ops4", PERF_OPS, 4);
`else
    chk("perf_ops4", PERF_OPS, 0);
`endif
    chk("perf_stall_after_rst", PERF_STALL, 0);
    chk("final_idle", BUSY, 0);
    repeat (3) tick();
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_sequencer.md
# exec_sequencer

Issue/retire controller for the execute stage. Accepts one decoded operation at a time from decode over a valid/ready handshake and pulses the execution unit to launch it. It times the op's fixed latency by class (ALU, MUL, DIV), then holds the completed result's tag for writeback until the downstream stage takes it. It is the sole stall source for the execute stage.

## Interface
Parameters:
- MUL_LAT, 3, multiply latency in cycles, legal 1..15
- DIV_LAT, 32, divide latency in cycles, legal 1..63

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- IN_VALID  in  1  decode presents an op
- IN_READY  out  1  sequencer can accept this cycle
- IN_CLASS  in  2  0=ALU, 1=MUL, 2=DIV, 3=reserved (treated as ALU)
- IN_RD  in  5  destination register tag
- EX_START  out  1  one-cycle launch pulse to execution unit (operand capture)
- EX_CLASS  out  2  class of the in-flight op, registered
- OUT_VALID  out  1  result ready for writeback
- OUT_READY  in  1  writeback takes result
- OUT_RD  out  5  tag of completed op, registered
- FLUSH  in  1  synchronous abort of in-flight/pending op
- BUSY  out  1  state != IDLE
- PERF_STALL  out  32  stall-cycle count (see Configuration)
- PERF_OPS  out  32  retired-op count (see Configuration)

## Operation
- FSM states: IDLE, EXEC, DONE.
- Accept = IN_VALID && IN_READY. IN_READY = !FLUSH && (IDLE || (DONE && OUT_READY)). This is a combinational path OUT_READY->IN_READY, permitted for back-to-back issue.
- EX_START = accept, combinational.
- On accept, latch EX_CLASS and OUT_RD (held in reg, OUT_RD updated at accept). Select LAT: ALU=1, MUL=MUL_LAT, DIV=DIV_LAT.
  - LAT==1: next state DONE.
  - Else: next state EXEC, cnt <= LAT-2.
- EXEC: cnt==0 -> DONE; else cnt--. IN_READY=0 throughout.
- DONE: OUT_VALID=1. On OUT_READY: accept in the same cycle -> apply accept rules; no accept -> IDLE.
- Counter width 6 bits, sufficient for DIV_LAT-2 max 61. No wrap occurs.
- FLUSH (priority over everything except RST): next state IDLE, cnt cleared. No EX_START and IN_READY=0 in the FLUSH cycle. An OUT_VALID present in the FLUSH cycle is not considered transferred even if OUT_READY=1. Downstream must ignore it.
- IN_CLASS=3 behaves exactly as ALU.

## Timing
- Reset values: state IDLE, cnt 0, OUT_VALID 0, OUT_RD 0, EX_CLASS 0, BUSY 0, PERF_* 0. IN_READY=1 after reset release if FLUSH low.
- Accept sampled at edge k -> OUT_VALID high after edge k+LAT-1. ALU: next cycle. MUL default: after edge k+2. DIV default: after edge k+31.
- Throughput with OUT_READY held high: one op per LAT cycles, no bubbles.
- OUT_VALID and OUT_RD stable while OUT_READY low.
- RST asserted mid-op: immediate return to reset values. The op is lost; no OUT_VALID.
- FLUSH at edge k -> OUT_VALID low, BUSY low after edge k.

## Configuration
- EXEC_SEQ_PERF_EN defined:
  - PERF_STALL increments each cycle IN_VALID && !IN_READY.
  - PERF_OPS increments on each DONE->handshake (OUT_VALID && OUT_READY && !FLUSH).
  - Both counters are 32-bit, wrap modulo 2^32, and are cleared only by RST.
- Not defined: counter logic is absent; PERF_STALL and PERF_OPS are tied to 0.

## Test plan
- ALU op, IN_RD=5, OUT_READY=1 -> EX_START at accept cycle, OUT_VALID=1 with OUT_RD=5 exactly one cycle later, back to IDLE next.
- Three MUL ops back-to-back (MUL_LAT=3), IN_VALID and OUT_READY held 1 -> EX_START every 3 cycles, 3 OUT_VALID pulses, tags in order, zero idle cycles.
- DIV op (DIV_LAT=32), OUT_READY low for 5 cycles after OUT_VALID rises -> OUT_VALID/OUT_RD held 5 cycles; IN_READY=0 throughout; PERF_STALL advances by 36 if IN_VALID held (with EXEC_SEQ_PERF_EN).
- DIV accepted, FLUSH at cycle 10 -> BUSY=0 next cycle, no OUT_VALID ever for that tag; next ALU op accepted the cycle after FLUSH deasserts.
- RST asserted mid-MUL -> all outputs at reset values asynchronously; after release a new ALU op completes in 1 cycle.
- 4 retired ops with EXEC_SEQ_PERF_EN -> PERF_OPS=4; without macro -> PERF_OPS=0, PERF_STALL=0 always.
